world_grid: RTL and testbench

WORLD_GRID -- requirements
Module: world_grid

---
 rtl/world_grid.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_world_grid.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/world_grid.sv
// world_grid: grid world for a robot controller. It holds a cell map, a robot
// pose and a three-phase scheduler (IDLE / SENSE / ACT). The scheduler drives
// robot_clock, updates the sensors from the map and applies robot commands,
// including multi-phase barrier removal.
module world_grid #(
  parameter  int ROWS         = 10,
  parameter  int COLS         = 20,
  parameter  int PHASE_CYCLES = 1,
  parameter  int REMOVE_STEPS = 3,
  localparam int AW           = $clog2(ROWS * COLS),
  localparam int PW           = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [2:0]    load_data,
  input  logic          pos_we,
  input  logic [PW-1:0] pos_row,
  input  logic [PW-1:0] pos_col,
  input  logic [1:0]    pos_orient,
  input  logic          front,
  input  logic          turn,
  input  logic          remove,
  output logic          robot_clock,
  output logic          head,
  output logic          left,
  output logic          under,
  output logic          barrier,
  output logic [PW-1:0] robot_row,
  output logic [PW-1:0] robot_column,
  output logic [1:0]    robot_orientation,
  input  logic [AW-1:0] rd_addr,
  output logic [2:0]    rd_data,
  output logic [7:0]    removed_count,
  output logic          collision,
  output logic          bad_load
);

  localparam int CELLS = ROWS * COLS;
  localparam int PCW   = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int RCW   = $clog2(REMOVE_STEPS + 1);

  localparam logic [PW-1:0]  ROW_LAST    = PW'(ROWS - 1);
  localparam logic [PW-1:0]  COL_LAST    = PW'(COLS - 1);
  localparam logic [AW:0]    CELLS_W     = (AW + 1)'(CELLS);
  localparam logic [PCW-1:0] PHASE_LAST  = PCW'(PHASE_CYCLES - 1);
  localparam logic [RCW-1:0] REMOVE_LAST = RCW'(REMOVE_STEPS - 1);

  localparam logic [2:0] CELL_EMPTY   = 3'd0;
  localparam logic [2:0] CELL_WALL    = 3'd1;
  localparam logic [2:0] CELL_BARRIER = 3'd2;
  localparam logic [2:0] CELL_DIRT    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SENSE = 2'd1,
    S_ACT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OR_NORTH = 2'b00,
    OR_SOUTH = 2'b01,
    OR_EAST  = 2'b10,
    OR_WEST  = 2'b11
  } orient_t;

  // A neighbouring cell: coordinates plus whether it lies inside the grid.
  typedef struct packed {
    logic          on_grid;
    logic [PW-1:0] row;
    logic [PW-1:0] col;
  } cell_ref_t;

  function automatic orient_t f_left_of(orient_t o);
    case (o)
      OR_NORTH: return OR_WEST;
      OR_SOUTH: return OR_EAST;
      OR_EAST:  return OR_NORTH;
      default:  return OR_SOUTH;
    endcase
  endfunction

  // One step from (row, col) towards o; off-grid keeps the original coords.
  function automatic cell_ref_t f_neighbor(logic [PW-1:0] row, logic [PW-1:0] col,
                                           orient_t o);
    cell_ref_t n;
    n.on_grid = 1'b1;
    n.row     = row;
    n.col     = col;
    case (o)
      OR_NORTH: if (row == '0)       n.on_grid = 1'b0; else n.row = row - PW'(1);
      OR_SOUTH: if (row == ROW_LAST) n.on_grid = 1'b0; else n.row = row + PW'(1);
      OR_EAST:  if (col == COL_LAST) n.on_grid = 1'b0; else n.col = col + PW'(1);
      default:  if (col == '0)       n.on_grid = 1'b0; else n.col = col - PW'(1);
    endcase
    return n;
  endfunction

  function automatic logic [AW-1:0] f_addr(logic [PW-1:0] row, logic [PW-1:0] col);
    return AW'(int'(row) * COLS + int'(col));
  endfunction

  // Registers
  state_t         r_state;
  logic [PCW-1:0] r_phase_cnt;
  logic [2:0]     r_map [CELLS];
  logic [PW-1:0]  r_row;
  logic [PW-1:0]  r_col;
  orient_t        r_orient;
  logic           r_head;
  logic           r_left;
  logic           r_under;
  logic           r_barrier;
  logic           r_collision;
  logic           r_bad_load;
  logic [RCW-1:0] r_rm_cnt;
  logic [7:0]     r_removed_count;
  logic [2:0]     r_rd_data;

  // Combinational signals
  state_t         w_state_next;
  logic [PCW-1:0] w_phase_next;
  logic           w_idle;
  logic           w_phase_last;
  logic           w_sense_last;
  logic           w_act_last;
  cell_ref_t      w_ahead;
  cell_ref_t      w_left_ref;
  logic [AW-1:0]  w_ahead_addr;
  logic [AW-1:0]  w_left_addr;
  logic [AW-1:0]  w_here_addr;
  logic [2:0]     w_ahead_code;
  logic [2:0]     w_left_code;
  logic [2:0]     w_here_code;
  logic           w_ahead_blocked;
  logic           w_ahead_is_barrier;
  logic           w_left_blocked;
  logic           w_move;
  logic           w_bump;
  logic           w_turn;
  logic           w_rm_hit;
  logic           w_rm_done;
  logic           w_pos_in_range;
  logic           w_load_in_range;
  logic           w_rd_in_range;
  logic           w_pos_ok;
  logic           w_load_ok;
  logic           w_bad_req;
  logic           w_map_we;
  logic [AW-1:0]  w_map_addr;
  logic [2:0]     w_map_data;

  // Phase decode
  assign w_idle       = (r_state == S_IDLE);
  assign w_phase_last = (r_phase_cnt == PHASE_LAST);
  assign w_sense_last = (r_state == S_SENSE) && w_phase_last;
  assign w_act_last   = (r_state == S_ACT) && w_phase_last;

  // Neighbourhood of the current pose
  assign w_ahead      = f_neighbor(r_row, r_col, r_orient);
  assign w_left_ref   = f_neighbor(r_row, r_col, f_left_of(r_orient));
  assign w_ahead_addr = f_addr(w_ahead.row, w_ahead.col);
  assign w_left_addr  = f_addr(w_left_ref.row, w_left_ref.col);
  assign w_here_addr  = f_addr(r_row, r_col);
  assign w_ahead_code = w_ahead.on_grid ? r_map[w_ahead_addr] : CELL_EMPTY;
  assign w_left_code  = w_left_ref.on_grid ? r_map[w_left_addr] : CELL_EMPTY;
  assign w_here_code  = r_map[w_here_addr];

  assign w_ahead_is_barrier = w_ahead.on_grid && (w_ahead_code == CELL_BARRIER);
  assign w_ahead_blocked    = !w_ahead.on_grid || (w_ahead_code == CELL_WALL) ||
                              (w_ahead_code == CELL_BARRIER);
  assign w_left_blocked     = !w_left_ref.on_grid || (w_left_code == CELL_WALL);

  // Command decode: front wins over turn; removal only counts while the pose holds
  assign w_move    = w_act_last && front && !w_ahead_blocked;
  assign w_bump    = w_act_last && front && w_ahead_blocked;
  assign w_turn    = w_act_last && !front && turn;
  assign w_rm_hit  = w_act_last && remove && w_ahead_is_barrier && !w_move && !w_turn;
  assign w_rm_done = w_rm_hit && (r_rm_cnt == REMOVE_LAST);

  // Host write qualification: only honoured while idle, range-checked
  assign w_pos_in_range  = (pos_row <= ROW_LAST) && (pos_col <= COL_LAST);
  assign w_load_in_range = ({1'b0, load_addr} < CELLS_W);
  assign w_rd_in_range   = ({1'b0, rd_addr} < CELLS_W);
  assign w_pos_ok        = w_idle && pos_we && w_pos_in_range;
  assign w_load_ok       = w_idle && load_we && w_load_in_range;
  assign w_bad_req       = w_idle && ((pos_we && !w_pos_in_range) ||
                                      (load_we && !w_load_in_range));

  // Single map write port; load (IDLE) and removal (ACT) never coincide
  assign w_map_we   = reset && (w_rm_done || w_load_ok);
  assign w_map_addr = w_rm_done ? w_ahead_addr : load_addr;
  assign w_map_data = w_rm_done ? CELL_EMPTY : load_data;

  // Phase scheduler state register
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_phase_cnt <= w_phase_next;
    end
  end

  // Next-phase logic: each phase runs to completion, then run decides where to go
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (which would infer a latch).
    w_state_next = r_state;
    w_phase_next = r_phase_cnt + PCW'(1);
    case (r_state)
      S_IDLE: begin
        w_phase_next = '0;
        if (run) w_state_next = S_SENSE;
      end
      S_SENSE: begin
        if (w_phase_last) begin
          w_phase_next = '0;
          w_state_next = run ? S_ACT : S_IDLE;
        end
      end
      S_ACT: begin
        if (w_phase_last) begin
          w_phase_next = '0;
          w_state_next = run ? S_SENSE : S_IDLE;
        end
      end
      default: begin
        w_phase_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sensors latch on the last SENSE cycle and hold otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head    <= 1'b0;
      r_left    <= 1'b0;
      r_under   <= 1'b0;
      r_barrier <= 1'b0;
    end else if (w_sense_last) begin
      r_head    <= !w_ahead.on_grid || (w_ahead_code == CELL_WALL);
      r_left    <= w_left_blocked;
      r_under   <= (w_here_code == CELL_DIRT);
      r_barrier <= w_ahead_is_barrier;
    end
  end

  // Pose: host load while idle, otherwise move/turn on the last ACT cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row    <= '0;
      r_col    <= '0;
      r_orient <= OR_NORTH;
    end else if (w_pos_ok) begin
      r_row    <= pos_row;
      r_col    <= pos_col;
      r_orient <= orient_t'(pos_orient);
    end else if (w_move) begin
      r_row <= w_ahead.row;
      r_col <= w_ahead.col;
    end else if (w_turn) begin
      r_orient <= f_left_of(r_orient);
    end
  end

  // One-cycle status pulses: blocked move and rejected host write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_collision <= 1'b0;
      r_bad_load  <= 1'b0;
    end else begin
      r_collision <= w_bump;
      r_bad_load  <= w_bad_req;
    end
  end

  // Barrier removal progress and saturating count of cleared barriers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rm_cnt        <= '0;
      r_removed_count <= '0;
    end else begin
      if (w_rm_done) begin
        r_rm_cnt <= '0;
        if (r_removed_count != 8'hFF) r_removed_count <= r_removed_count + 8'd1;
      end else if (w_rm_hit) begin
        r_rm_cnt <= r_rm_cnt + RCW'(1);
      end else if (w_act_last || w_pos_ok) begin
        r_rm_cnt <= '0;
      end
    end
  end

  // Map storage write port
  always_ff @(posedge clock) begin
    // NOTE: the map is storage, not control state: it has no reset so its contents survive one.
    if (w_map_we) r_map[w_map_addr] <= w_map_data;
  end

  // Registered display read port (read-before-write on an address clash)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_rd_data <= CELL_EMPTY;
    else        r_rd_data <= w_rd_in_range ? r_map[rd_addr] : CELL_EMPTY;
  end

  assign robot_clock       = (r_state == S_ACT);
  assign head              = r_head;
  assign left              = r_left;
  assign under             = r_under;
  assign barrier           = r_barrier;
  assign robot_row         = r_row;
  assign robot_column      = r_col;
  assign robot_orientation = r_orient;
  assign rd_data           = r_rd_data;
  assign removed_count     = r_removed_count;
  assign collision         = r_collision;
  assign bad_load          = r_bad_load;

endmodule

// File: tb/tb_world_grid.sv
// tb_world_grid: self-checking bench for world_grid. A behavioural robot-world
// model (map array, pose as integers, per-phase rule application) predicts
// sensors, pose, collisions and removals for directed and random scenarios.
module tb_world_grid;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int PC    = 3;
  localparam int RS    = 3;
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int PW    = 6;

  logic          clock;
  logic          reset;
  logic          run;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_data;
  logic          pos_we;
  logic [PW-1:0] pos_row;
  logic [PW-1:0] pos_col;
  logic [1:0]    pos_orient;
  logic          front;
  logic          turn;
  logic          remove;
  logic          robot_clock;
  logic          head;
  logic          left;
  logic          under;
  logic          barrier;
  logic [PW-1:0] robot_row;
  logic [PW-1:0] robot_column;
  logic [1:0]    robot_orientation;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic [7:0]    removed_count;
  logic          collision;
  logic          bad_load;

  world_grid #(
    .ROWS(ROWS), .COLS(COLS), .PHASE_CYCLES(PC), .REMOVE_STEPS(RS)
  ) dut (
    .clock(clock), .reset(reset), .run(run),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .pos_we(pos_we), .pos_row(pos_row), .pos_col(pos_col), .pos_orient(pos_orient),
    .front(front), .turn(turn), .remove(remove),
    .robot_clock(robot_clock),
    .head(head), .left(left), .under(under), .barrier(barrier),
    .robot_row(robot_row), .robot_column(robot_column),
    .robot_orientation(robot_orientation),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .removed_count(removed_count), .collision(collision), .bad_load(bad_load)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;

  // Reference world
  int m_map [CELLS];
  int m_row, m_col, m_or;
  int m_cnt;
  int m_removed;

  // Orientation arithmetic: 0 N, 1 S, 2 E, 3 W
  function automatic int dr(int o);
    return (o == 0) ? -1 : (o == 1) ? 1 : 0;
  endfunction
  function automatic int dc(int o);
    return (o == 2) ? 1 : (o == 3) ? -1 : 0;
  endfunction
  function automatic int lt(int o);
    return (o == 0) ? 3 : (o == 1) ? 2 : (o == 2) ? 0 : 1;
  endfunction

  // -1 marks off-grid
  function automatic int cell_at(int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return -1;
    return m_map[r * COLS + c];
  endfunction

  function automatic logic [3:0] model_sensors();
    int a, l, h;
    a = cell_at(m_row + dr(m_or), m_col + dc(m_or));
    l = cell_at(m_row + dr(lt(m_or)), m_col + dc(lt(m_or)));
    h = cell_at(m_row, m_col);
    return {(a == -1 || a == 1), (l == -1 || l == 1), (h == 7), (a == 2)};
  endfunction

  task automatic model_act(input bit f, input bit t, input bit rm, output bit coll);
    int ar, ac, a;
    bit moved;
    ar = m_row + dr(m_or);
    ac = m_col + dc(m_or);
    a = cell_at(ar, ac);
    moved = 1'b0;
    coll = 1'b0;
    if (f) begin
      if (a == -1 || a == 1 || a == 2) coll = 1'b1;
      else begin
        m_row = ar;
        m_col = ac;
        moved = 1'b1;
      end
    end else if (t) begin
      m_or = lt(m_or);
      moved = 1'b1;
    end
    if (moved) m_cnt = 0;
    else if (rm && a == 2) begin
      m_cnt++;
      if (m_cnt == RS) begin
        m_map[ar * COLS + ac] = 0;
        if (m_removed < 255) m_removed++;
        m_cnt = 0;
      end
    end else m_cnt = 0;
  endtask

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    m_or = 0;
    m_cnt = 0;
    m_removed = 0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    run = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    pos_we = 1'b0; pos_row = '0; pos_col = '0; pos_orient = '0;
    front = 1'b0; turn = 1'b0; remove = 1'b0; rd_addr = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic load_map();
    for (int i = 0; i < CELLS; i++) begin
      load_we = 1'b1;
      load_addr = AW'(i);
      load_data = 3'(m_map[i]);
      tick();
    end
    load_we = 1'b0;
  endtask

  task automatic clear_model_map();
    for (int i = 0; i < CELLS; i++) m_map[i] = 0;
  endtask

  task automatic set_pose(input int r, input int c, input int o);
    pos_we = 1'b1;
    pos_row = PW'(r);
    pos_col = PW'(c);
    pos_orient = 2'(o);
    tick();
    pos_we = 1'b0;
    m_row = r;
    m_col = c;
    m_or = o;
    m_cnt = 0;
  endtask

  task automatic read_cell(input int a, output logic [2:0] d);
    rd_addr = AW'(a);
    tick();
    d = rd_data;
  endtask

  task automatic check_map(input string tag);
    logic [2:0] d;
    for (int i = 0; i < CELLS; i++) begin
      read_cell(i, d);
      n_chk++;
      if (d !== 3'(m_map[i]))
        $display("FAIL %s map[%0d]: got %0d want %0d", tag, i, d, m_map[i]);
      else n_pass++;
    end
  endtask

  // Called in IDLE: the next edge enters SENSE
  task automatic start_run();
    run = 1'b1;
    tick();
  endtask

  // Called at the start of a SENSE phase: it completes, then IDLE
  task automatic stop_run();
    run = 1'b0;
    repeat (PC) tick();
  endtask

  // One SENSE+ACT pair starting at the first SENSE cycle
  task automatic do_pair(input bit f, input bit t, input bit rm);
    logic [3:0] e_sens;
    bit e_coll;
    for (int i = 0; i < PC; i++) begin
      tick();
      if (i == 0) begin
        n_chk++;
        if (collision !== 1'b0) $display("FAIL collision_pulse_end: got %b want 0", collision);
        else n_pass++;
      end
    end
    e_sens = model_sensors();
    n_chk++;
    if (robot_clock !== 1'b1) $display("FAIL robot_clock_act: got %b want 1", robot_clock);
    else n_pass++;
    n_chk++;
    if ({head, left, under, barrier} !== e_sens)
      $display("FAIL sensors: got %b want %b (pose %0d,%0d,%0d)",
               {head, left, under, barrier}, e_sens, m_row, m_col, m_or);
    else n_pass++;
    front = f;
    turn = t;
    remove = rm;
    model_act(f, t, rm, e_coll);
    repeat (PC) tick();
    front = 1'b0;
    turn = 1'b0;
    remove = 1'b0;
    n_chk++;
    if ({robot_row, robot_column, robot_orientation} !== {PW'(m_row), PW'(m_col), 2'(m_or)})
      $display("FAIL pose: got %0d,%0d,%0d want %0d,%0d,%0d", robot_row, robot_column,
               robot_orientation, m_row, m_col, m_or);
    else n_pass++;
    n_chk++;
    if (collision !== e_coll) $display("FAIL collision: got %b want %b", collision, e_coll);
    else n_pass++;
    n_chk++;
    if (removed_count !== 8'(m_removed))
      $display("FAIL removed_count: got %0d want %0d", removed_count, m_removed);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string tag);
    n_chk++;
    if (robot_clock !== 1'b0) $display("FAIL %s robot_clock: got %b want 0", tag, robot_clock);
    else n_pass++;
    n_chk++;
    if ({head, left, under, barrier} !== 4'b0000)
      $display("FAIL %s sensors: got %b want 0000", tag, {head, left, under, barrier});
    else n_pass++;
    n_chk++;
    if ({robot_row, robot_column, robot_orientation} !== 14'd0)
      $display("FAIL %s pose: got %0d,%0d,%0d want 0,0,0", tag, robot_row, robot_column,
               robot_orientation);
    else n_pass++;
    n_chk++;
    if ({removed_count, collision, bad_load, rd_data} !== 13'd0)
      $display("FAIL %s status: got rc=%0d col=%b bad=%b rd=%0d want all 0", tag,
               removed_count, collision, bad_load, rd_data);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    check_reset_values("reset");
    tick();
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_forward();
    apply_reset();
    clear_model_map();
    load_map();
    set_pose(0, 0, 2);
    start_run();
    repeat (5) do_pair(1'b1, 1'b0, 1'b0);
    n_chk++;
    if (robot_column !== 6'd4) $display("FAIL forward_final_col: got %0d want 4", robot_column);
    else n_pass++;
    stop_run();
  endtask

  task automatic test_barrier();
    logic [2:0] d;
    apply_reset();
    clear_model_map();
    m_map[7] = 2;
    load_map();
    set_pose(1, 1, 2);
    start_run();
    repeat (3) do_pair(1'b0, 1'b0, 1'b1);
    do_pair(1'b0, 1'b0, 1'b0);
    stop_run();
    read_cell(7, d);
    n_chk++;
    if (d !== 3'd0) $display("FAIL barrier_cleared: got %0d want 0", d);
    else n_pass++;
    n_chk++;
    if (removed_count !== 8'd1) $display("FAIL barrier_count: got %0d want 1", removed_count);
    else n_pass++;
  endtask

  task automatic test_barrier_interrupt();
    logic [2:0] d;
    apply_reset();
    clear_model_map();
    m_map[7] = 2;
    load_map();
    set_pose(1, 1, 2);
    start_run();
    do_pair(1'b0, 1'b0, 1'b1);
    do_pair(1'b0, 1'b0, 1'b1);
    do_pair(1'b0, 1'b0, 1'b0);
    do_pair(1'b0, 1'b0, 1'b1);
    do_pair(1'b0, 1'b0, 1'b1);
    stop_run();
    read_cell(7, d);
    n_chk++;
    if (d !== 3'd2) $display("FAIL barrier_kept: got %0d want 2", d);
    else n_pass++;
    n_chk++;
    if (removed_count !== 8'd0) $display("FAIL barrier_kept_count: got %0d want 0", removed_count);
    else n_pass++;
  endtask

  task automatic test_turn();
    apply_reset();
    clear_model_map();
    load_map();
    set_pose(0, 0, 0);
    start_run();
    repeat (4) do_pair(1'b0, 1'b1, 1'b0);
    stop_run();
  endtask

  task automatic test_phase_and_reset();
    bit e_rc;
    apply_reset();
    clear_model_map();
    m_map[2] = 1;
    m_map[3] = 7;
    load_map();
    set_pose(0, 3, 0);
    start_run();
    for (int k = 1; k <= 2 * PC; k++) begin
      tick();
      e_rc = ((k / PC) % 2) == 1;
      n_chk++;
      if (robot_clock !== e_rc) $display("FAIL robot_clock_period k=%0d: got %b want %b", k,
                                         robot_clock, e_rc);
      else n_pass++;
    end
    repeat (PC) tick();
    tick();
    n_chk++;
    if ({robot_clock, head, left, under, barrier} !== {1'b1, model_sensors()})
      $display("FAIL pre_reset_state: got %b want %b", {robot_clock, head, left, under, barrier},
               {1'b1, model_sensors()});
    else n_pass++;
    reset = 1'b0;
    #1;
    check_reset_values("mid_act_reset");
    run = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    check_map("retained");
  endtask

  task automatic test_idle_writes();
    logic [2:0] d;
    apply_reset();
    clear_model_map();
    load_map();
    set_pose(1, 1, 2);
    start_run();
    do_pair(1'b0, 1'b0, 1'b0);
    load_we = 1'b1; load_addr = AW'(7); load_data = 3'd1;
    pos_we = 1'b1; pos_row = 6'd3; pos_col = 6'd3; pos_orient = 2'd1;
    do_pair(1'b0, 1'b0, 1'b0);
    load_we = 1'b0;
    pos_we = 1'b0;
    do_pair(1'b0, 1'b0, 1'b0);
    stop_run();
    read_cell(7, d);
    n_chk++;
    if (d !== 3'd0) $display("FAIL load_while_running: got %0d want 0", d);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      pos_row = (i == 0) ? 6'd4 : 6'd0;
      pos_col = (i == 1) ? 6'd5 : 6'd0;
      pos_orient = 2'd3;
      pos_we = (i != 2);
      load_we = (i == 2);
      load_addr = AW'(20);
      load_data = 3'd1;
      tick();
      pos_we = 1'b0;
      load_we = 1'b0;
      n_chk++;
      if (bad_load !== 1'b1) $display("FAIL bad_load_pulse case %0d: got %b want 1", i, bad_load);
      else n_pass++;
      tick();
      n_chk++;
      if (bad_load !== 1'b0) $display("FAIL bad_load_width case %0d: got %b want 0", i, bad_load);
      else n_pass++;
      n_chk++;
      if ({robot_row, robot_column, robot_orientation} !== {PW'(m_row), PW'(m_col), 2'(m_or)})
        $display("FAIL bad_pose_ignored case %0d: got %0d,%0d,%0d want %0d,%0d,%0d", i,
                 robot_row, robot_column, robot_orientation, m_row, m_col, m_or);
      else n_pass++;
    end
  endtask

  task automatic test_read_during_write();
    int old_v, new_v;
    old_v = m_map[3];
    new_v = (old_v == 7) ? 1 : 7;
    rd_addr = AW'(3);
    load_we = 1'b1;
    load_addr = AW'(3);
    load_data = 3'(new_v);
    tick();
    load_we = 1'b0;
    n_chk++;
    if (rd_data !== 3'(old_v)) $display("FAIL read_old_on_write: got %0d want %0d", rd_data, old_v);
    else n_pass++;
    tick();
    n_chk++;
    if (rd_data !== 3'(new_v)) $display("FAIL read_after_write: got %0d want %0d", rd_data, new_v);
    else n_pass++;
    m_map[3] = new_v;
  endtask

  function automatic int rand_code();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 4) return 0;
    if (k == 4) return 1;
    if (k < 7) return 2;
    if (k == 7) return 7;
    return int'($urandom_range(3, 6));
  endfunction

  task automatic test_random();
    bit f, t, rm;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < CELLS; i++) m_map[i] = rand_code();
      load_map();
      set_pose(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
               int'($urandom_range(0, 3)));
      start_run();
      for (int p = 0; p < 30; p++) begin
        f = ($urandom_range(0, 99) < 30);
        t = ($urandom_range(0, 99) < 25);
        rm = ($urandom_range(0, 99) < 80);
        do_pair(f, t, rm);
      end
      stop_run();
      check_map("random");
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_forward();
    test_barrier();
    test_barrier_interrupt();
    test_turn();
    test_phase_and_reset();
    test_idle_writes();
    test_read_during_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
